// File: rtl/game_sequencer.sv
// Top-level battleship game FSM: phase sequencing, player turn timing, PC attack issue and hit tally.
// State encoding is one-hot with IDLE as all-zero, so the phase flags are the state register itself.
module game_sequencer #(
    parameter int TURN_CYCLES = 750_000_000,
    parameter int PC_DELAY    = 50_000_000,
    parameter int MAX_SHIPS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [2:0] ship_amount_sw,
    input  logic       finished_placing,
    input  logic       finished_setUp,
    input  logic       attack_done,
    input  logic       attack_hit,
    input  logic [4:0] ship_cells_total,
    output logic [2:0] ship_amount,
    output logic       colocation_ships_State,
    output logic       setup_State,
    output logic       player_turn_State,
    output logic       pc_turn_State,
    output logic       win_State,
    output logic       lose_State,
    output logic       pc_attack,
    output logic [2:0] pc_i,
    output logic [2:0] pc_j,
    output logic [3:0] seconds_left
);
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000000,
        ST_COLOC  = 6'b000001,
        ST_SETUP  = 6'b000010,
        ST_PTURN  = 6'b000100,
        ST_PCTURN = 6'b001000,
        ST_WIN    = 6'b010000,
        ST_LOSE   = 6'b100000
    } state_t;

    localparam int TW = $clog2(TURN_CYCLES);
    localparam int DW = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [DW-1:0] DELAY_LAST = DW'(PC_DELAY - 1);
    // seconds_left = 15 - floor(t*15/T); split 15 = K*T + R so each cycle drops K or K+1 seconds
    localparam logic [TW:0]   ACC_R      = (TW+1)'(15 % TURN_CYCLES);
    localparam logic [TW:0]   ACC_T      = (TW+1)'(TURN_CYCLES);
    localparam logic [3:0]    SEC_STEP   = 4'(15 / TURN_CYCLES);
    localparam logic [3:0]    SEC_STEP1  = 4'(15 / TURN_CYCLES + 1);
    localparam logic [2:0]    MAX_AMT    = 3'(MAX_SHIPS);

    state_t          r_state;
    logic            r_btn_prev;
    logic [7:0]      r_lfsr;
    logic [TW-1:0]   r_timer;
    logic [TW:0]     r_sec_acc;
    logic [3:0]      r_secs;
    logic [DW-1:0]   r_delay;
    logic            r_fired;
    logic [4:0]      r_p_hits;
    logic [4:0]      r_pc_hits;
    logic [2:0]      r_amt;
    logic            r_pc_attack;
    logic [2:0]      r_pc_i;
    logic [2:0]      r_pc_j;

    logic            w_press;
    logic            w_lfsr_fb;
    logic [TW:0]     w_acc_sum;
    logic            w_sec_tick;
    logic [5:0]      w_p_sum;
    logic [5:0]      w_pc_sum;
    logic [4:0]      w_p_next;
    logic [4:0]      w_pc_next;
    logic [2:0]      w_amt_clamped;

    function automatic logic [2:0] mod5(input logic [2:0] v);
        return (v > 3'd4) ? v - 3'd5 : v;
    endfunction

    assign w_press    = r_btn_prev & ~start_btn;
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_acc_sum  = r_sec_acc + ACC_R;
    assign w_sec_tick = (w_acc_sum >= ACC_T);
    assign w_p_sum    = {1'b0, r_p_hits} + {5'd0, attack_hit};
    assign w_pc_sum   = {1'b0, r_pc_hits} + {5'd0, attack_hit};
    assign w_p_next   = (w_p_sum > 6'd25) ? 5'd25 : w_p_sum[4:0];
    assign w_pc_next  = (w_pc_sum > 6'd25) ? 5'd25 : w_pc_sum[4:0];

    always_comb begin
        w_amt_clamped = ship_amount_sw;
        if (ship_amount_sw == 3'd0)
            w_amt_clamped = 3'd1;
        else if (ship_amount_sw > MAX_AMT)
            w_amt_clamped = MAX_AMT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_btn_prev  <= 1'b0;
            r_lfsr      <= 8'hA5;
            r_timer     <= '0;
            r_sec_acc   <= '0;
            r_secs      <= 4'd0;
            r_delay     <= '0;
            r_fired     <= 1'b0;
            r_p_hits    <= 5'd0;
            r_pc_hits   <= 5'd0;
            r_amt       <= 3'd0;
            r_pc_attack <= 1'b0;
            r_pc_i      <= 3'd0;
            r_pc_j      <= 3'd0;
        end else begin
            r_btn_prev  <= start_btn;
            r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
            r_pc_attack <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_press) begin
                    r_amt   <= w_amt_clamped;
                    r_state <= ST_COLOC;
                end
                ST_COLOC: if (finished_placing) r_state <= ST_SETUP;
                ST_SETUP: if (finished_setUp) begin
                    r_state   <= ST_PTURN;
                    r_timer   <= '0;
                    r_sec_acc <= '0;
                    r_secs    <= 4'd15;
                    r_p_hits  <= 5'd0;
                    r_pc_hits <= 5'd0;
                end
                ST_PTURN: begin
                    if (attack_done || r_timer == TIMER_LAST) begin
                        r_secs  <= 4'd0;
                        r_delay <= DELAY_LAST;
                        r_fired <= 1'b0;
                        r_state <= ST_PCTURN;
                        if (attack_done) begin
                            r_p_hits <= w_p_next;
                            if (w_p_sum == {1'b0, ship_cells_total}) r_state <= ST_WIN;
                        end
                    end else begin
                        r_timer   <= r_timer + TW'(1);
                        r_sec_acc <= w_sec_tick ? w_acc_sum - ACC_T : w_acc_sum;
                        r_secs    <= r_secs - (w_sec_tick ? SEC_STEP1 : SEC_STEP);
                    end
                end
                ST_PCTURN: begin
                    if (!r_fired) begin
                        if (r_delay == '0) begin
                            r_pc_attack <= 1'b1;
                            r_pc_i      <= mod5(r_lfsr[2:0]);
                            r_pc_j      <= mod5(r_lfsr[5:3]);
                            r_fired     <= 1'b1;
                        end else begin
                            r_delay <= r_delay - DW'(1);
                        end
                    end else if (attack_done) begin
                        r_pc_hits <= w_pc_next;
                        if (w_pc_sum == {1'b0, ship_cells_total}) begin
                            r_state <= ST_LOSE;
                        end else begin
                            r_state   <= ST_PTURN;
                            r_timer   <= '0;
                            r_sec_acc <= '0;
                            r_secs    <= 4'd15;
                        end
                    end
                end
                ST_WIN, ST_LOSE: if (w_press) begin
                    r_state   <= ST_IDLE;
                    r_amt     <= 3'd0;
                    r_timer   <= '0;
                    r_sec_acc <= '0;
                    r_delay   <= '0;
                    r_fired   <= 1'b0;
                    r_p_hits  <= 5'd0;
                    r_pc_hits <= 5'd0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign colocation_ships_State = r_state[0];
    assign setup_State            = r_state[1];
    assign player_turn_State      = r_state[2];
    assign pc_turn_State          = r_state[3];
    assign win_State              = r_state[4];
    assign lose_State             = r_state[5];
    assign ship_amount            = r_amt;
    assign pc_attack              = r_pc_attack;
    assign pc_i                   = r_pc_i;
    assign pc_j                   = r_pc_j;
    assign seconds_left           = r_secs;
endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with short turn/delay parameters.
module tb_game_sequencer;
    localparam int TC = 20;
    localparam int PD = 3;
    localparam logic [5:0] S_IDLE = 6'b000000, S_COL = 6'b000001, S_SET = 6'b000010,
                           S_PT = 6'b000100, S_PC = 6'b001000, S_WIN = 6'b010000,
                           S_LOSE = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic [2:0] ship_amount_sw = 3'd0;
    logic       finished_placing = 1'b0;
    logic       finished_setUp = 1'b0;
    logic       attack_done = 1'b0;
    logic       attack_hit = 1'b0;
    logic [4:0] ship_cells_total = 5'd25;
    logic [2:0] ship_amount;
    logic       coloc_f, setup_f, pturn_f, pcturn_f, win_f, lose_f;
    logic       pc_attack;
    logic [2:0] pc_i, pc_j;
    logic [3:0] seconds_left;
    logic [5:0] dut_st;

    game_sequencer #(.TURN_CYCLES(TC), .PC_DELAY(PD), .MAX_SHIPS(5)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .ship_amount_sw(ship_amount_sw),
        .finished_placing(finished_placing), .finished_setUp(finished_setUp),
        .attack_done(attack_done), .attack_hit(attack_hit), .ship_cells_total(ship_cells_total),
        .ship_amount(ship_amount), .colocation_ships_State(coloc_f), .setup_State(setup_f),
        .player_turn_State(pturn_f), .pc_turn_State(pcturn_f), .win_State(win_f),
        .lose_State(lose_f), .pc_attack(pc_attack), .pc_i(pc_i), .pc_j(pc_j),
        .seconds_left(seconds_left)
    );

    assign dut_st = {lose_f, win_f, pcturn_f, pturn_f, setup_f, coloc_f};

    always #5 clk = ~clk;

    // Independent LFSR reference: m_prev holds the value the DUT saw at the last edge
    logic [7:0] m_lfsr, m_prev;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    typedef struct packed {
        logic       btn;
        logic [2:0] sw;
        logic       fp;
        logic       fs;
        logic       ad;
        logic       ah;
        logic [5:0] e_st;
        logic [2:0] e_amt;
        logic       e_pca;
        logic [3:0] e_secs;
    } vec_t;

    vec_t q[$];
    vec_t tbl[9];
    int   n_pass = 0;
    int   n_total = 0;
    logic [2:0] cur_amt = 3'd0;

    function automatic vec_t mk(logic btn, logic [2:0] sw, logic fp, logic fs, logic ad,
                                logic ah, logic [5:0] st, logic [2:0] amt, logic pca,
                                logic [3:0] secs);
        vec_t v;
        v.btn = btn; v.sw = sw; v.fp = fp; v.fs = fs; v.ad = ad; v.ah = ah;
        v.e_st = st; v.e_amt = amt; v.e_pca = pca; v.e_secs = secs;
        return v;
    endfunction

    function automatic logic [3:0] fsec(int k);
        return 4'(15 - (k * 15) / TC);
    endfunction

    function automatic logic [2:0] ref_mod5(logic [2:0] v);
        logic [2:0] r;
        r = v;
        if (v >= 3'd5) r = v - 3'd5;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        start_btn = v.btn; ship_amount_sw = v.sw; finished_placing = v.fp;
        finished_setUp = v.fs; attack_done = v.ad; attack_hit = v.ah;
        q.push_back(v);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, " state"}, int'(dut_st), int'(e.e_st));
        chk({tag, " ship_amount"}, int'(ship_amount), int'(e.e_amt));
        chk({tag, " pc_attack"}, int'(pc_attack), int'(e.e_pca));
        chk({tag, " seconds_left"}, int'(seconds_left), int'(e.e_secs));
        if (e.e_pca) begin
            chk({tag, " pc_i"}, int'(pc_i), int'(ref_mod5(m_prev[2:0])));
            chk({tag, " pc_j"}, int'(pc_j), int'(ref_mod5(m_prev[5:3])));
        end
    endtask

    task automatic idle_step(input string tag, input logic [5:0] st, input logic pca,
                             input logic [3:0] secs);
        step(tag, mk(0, 0, 0, 0, 0, 0, st, cur_amt, pca, secs));
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("reset state", int'(dut_st), 0);
        chk("reset outputs", int'({ship_amount, pc_attack, pc_i, pc_j, seconds_left}), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        cur_amt = 3'd0;
    endtask

    task automatic start_game(input logic [2:0] sw, input logic [2:0] amt);
        step("start hold", mk(1, sw, 0, 0, 0, 0, S_IDLE, 3'd0, 0, 0));
        step("start release", mk(0, sw, 0, 0, 0, 0, S_COL, amt, 0, 0));
        cur_amt = amt;
        step("placed", mk(0, 0, 1, 0, 0, 0, S_SET, amt, 0, 0));
        step("setup done", mk(0, 0, 0, 1, 0, 0, S_PT, amt, 0, 4'd15));
    endtask

    task automatic pc_strobe();
        idle_step("pc wait1", S_PC, 0, 0);
        idle_step("pc wait2", S_PC, 0, 0);
        idle_step("pc strobe", S_PC, 1, 0);
    endtask

    initial begin
        tbl[0] = mk(0, 3, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
        tbl[1] = mk(1, 3, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
        tbl[2] = mk(0, 3, 0, 0, 0, 0, S_COL,  3, 0, 0);
        tbl[3] = mk(1, 3, 0, 0, 0, 0, S_COL,  3, 0, 0);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, S_COL,  3, 0, 0);
        tbl[5] = mk(0, 0, 0, 1, 1, 1, S_COL,  3, 0, 0);
        tbl[6] = mk(0, 0, 1, 0, 0, 0, S_SET,  3, 0, 0);
        tbl[7] = mk(0, 0, 1, 0, 1, 1, S_SET,  3, 0, 0);
        tbl[8] = mk(0, 0, 0, 1, 0, 0, S_PT,   3, 0, 15);

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 9; i++) step($sformatf("tbl%0d", i), tbl[i]);
        cur_amt = 3'd3;

        // miss on cycle 5, PC strobe after PC_DELAY, early attack_done ignored
        for (int k = 1; k <= 5; k++) idle_step($sformatf("pturn t%0d", k), S_PT, 0, fsec(k));
        step("player miss", mk(0, 0, 0, 0, 1, 0, S_PC, cur_amt, 0, 0));
        step("early done", mk(0, 0, 0, 0, 1, 1, S_PC, cur_amt, 0, 0));
        idle_step("pc wait2", S_PC, 0, 0);
        idle_step("pc strobe", S_PC, 1, 0);
        idle_step("pc after strobe", S_PC, 0, 0);
        step("pc miss", mk(0, 0, 0, 0, 1, 0, S_PT, cur_amt, 0, 15));

        // turn timeout
        for (int k = 1; k < TC; k++) idle_step($sformatf("timeout t%0d", k), S_PT, 0, fsec(k));
        idle_step("timeout", S_PC, 0, 0);
        pc_strobe();
        step("pc miss2", mk(0, 0, 0, 0, 1, 0, S_PT, cur_amt, 0, 15));

        // two player hits across turns -> WIN, press -> IDLE; sw=7 clamps to 5
        do_reset();
        ship_cells_total = 5'd2;
        start_game(3'd7, 3'd5);
        step("p hit1", mk(0, 0, 0, 0, 1, 1, S_PC, cur_amt, 0, 0));
        pc_strobe();
        step("pc hit1", mk(0, 0, 0, 0, 1, 1, S_PT, cur_amt, 0, 15));
        step("p hit2", mk(0, 0, 0, 0, 1, 1, S_WIN, cur_amt, 0, 0));
        step("win hold", mk(1, 0, 0, 0, 1, 1, S_WIN, cur_amt, 0, 0));
        step("win press", mk(0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0));
        cur_amt = 3'd0;

        // PC reaches total -> LOSE; sw=0 maps to 1
        do_reset();
        ship_cells_total = 5'd1;
        start_game(3'd0, 3'd1);
        step("p miss", mk(0, 0, 0, 0, 1, 0, S_PC, cur_amt, 0, 0));
        pc_strobe();
        step("pc hit", mk(0, 0, 0, 0, 1, 1, S_LOSE, cur_amt, 0, 0));
        step("lose hold", mk(1, 0, 0, 0, 0, 0, S_LOSE, cur_amt, 0, 0));
        step("lose press", mk(0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0));

        // attack_done coinciding with timeout counts as an attack
        do_reset();
        start_game(3'd3, 3'd3);
        for (int k = 1; k < TC; k++) idle_step($sformatf("late t%0d", k), S_PT, 0, fsec(k));
        step("hit at timeout", mk(0, 0, 0, 0, 1, 1, S_WIN, cur_amt, 0, 0));

        // async reset in the middle of the PC delay
        do_reset();
        ship_cells_total = 5'd25;
        start_game(3'd2, 3'd2);
        step("p miss", mk(0, 0, 0, 0, 1, 0, S_PC, cur_amt, 0, 0));
        idle_step("pc wait1", S_PC, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("async rst state", int'(dut_st), 0);
        chk("async rst outputs", int'({ship_amount, pc_attack, pc_i, pc_j, seconds_left}), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (dut.r_lfsr == 8'h00 || dut.r_lfsr != m_lfsr) begin
                chk($sformatf("lfsr cycle %0d", c), int'(dut.r_lfsr), int'(m_lfsr));
            end
        end
        chk("lfsr final", int'(dut.r_lfsr), int'(m_lfsr));
        chk("lfsr nonzero", int'(dut.r_lfsr != 8'h00), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
